// File: rtl/mem_bus_pkg.sv
// Shared definitions for the SRAM bus controller: FSM states, wait-counter
// width and default parameter values.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_HOLD,
        ST_DONE
    } state_t;

    // Wide enough for WAIT_CYCLES up to 15
    localparam int CNT_W = 4;

    localparam int DEF_NUM_MASTERS = 2;
    localparam int DEF_NUM_BANKS   = 2;
    localparam int DEF_ADDR_W      = 20;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_WAIT_CYCLES = 2;

endpackage

// File: rtl/bus_arbiter.sv
// Master arbiter: one-hot grant plus index. Round-robin from ptr when
// SRAM_BUS_RR_EN is defined, otherwise fixed priority (lowest index wins).
module bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic [NUM_MASTERS-1:0] req,
`ifdef SRAM_BUS_RR_EN
    input  logic [IDX_W-1:0]       ptr,
`endif
    output logic [NUM_MASTERS-1:0] grant,
    output logic [IDX_W-1:0]       grant_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
`ifdef SRAM_BUS_RR_EN
            cand = IDX_W'((32'(ptr) + i) % NUM_MASTERS);
`else
            cand = IDX_W'(i);
`endif
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_bus_ctrl.sv
// Multi-master, multi-bank asynchronous SRAM controller with a fixed-length
// access phase. Macro SRAM_BUS_RR_EN selects round-robin arbitration.
module sram_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int NUM_BANKS   = DEF_NUM_BANKS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int SEL_W       = DATA_W / 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [NUM_MASTERS-1:0]        m_we,
    input  logic [NUM_MASTERS*32-1:0]     m_addr,
    input  logic [NUM_MASTERS*SEL_W-1:0]  m_sel,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]        m_ack,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [NUM_BANKS*ADDR_W-1:0]   ram_addr,
    output logic [NUM_BANKS*SEL_W-1:0]    ram_be_n,
    output logic [NUM_BANKS-1:0]          ram_ce_n,
    output logic [NUM_BANKS-1:0]          ram_oe_n,
    output logic [NUM_BANKS-1:0]          ram_we_n,
    output logic [DATA_W-1:0]             ram_dq_o,
    output logic                          ram_dq_oe,
    input  logic [NUM_BANKS*DATA_W-1:0]   ram_dq_i
);

    localparam int IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [31:0] USED_ADDR_MASK =
        ((32'd1 << (ADDR_W + $clog2(NUM_BANKS))) - 32'd1) << 2;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [NUM_MASTERS-1:0]  grant_oh, grant_oh_q;
    logic [IDX_W-1:0]        grant_idx;
    logic                    we_q;
    logic [ADDR_W-1:0]       waddr_q;
    logic [SEL_W-1:0]        sel_q;
    logic [BANK_W-1:0]       bank_q, bank_mux;
    logic [31:0]             addr_mux;
    logic                    req_any, access_last;
    logic                    unused_addr_bits;
`ifdef SRAM_BUS_RR_EN
    logic [IDX_W-1:0]        ptr;
`endif

    bus_arbiter #(
        .NUM_MASTERS(NUM_MASTERS),
        .IDX_W      (IDX_W)
    ) u_arb (
        .req      (m_req),
`ifdef SRAM_BUS_RR_EN
        .ptr      (ptr),
`endif
        .grant    (grant_oh),
        .grant_idx(grant_idx)
    );

    assign req_any          = |m_req;
    assign access_last      = (cnt == CNT_W'(WAIT_CYCLES - 1));
    assign addr_mux         = m_addr[grant_idx*32 +: 32];
    assign unused_addr_bits = ^(addr_mux & ~USED_ADDR_MASK);

    generate
        if (NUM_BANKS > 1) begin : g_bank_dec
            assign bank_mux = addr_mux[ADDR_W+2 +: BANK_W];
        end else begin : g_bank_one
            assign bank_mux = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            sel_q      <= '0;
            bank_q     <= '0;
            grant_oh_q <= '0;
            ram_dq_o   <= '0;
            m_rdata    <= '0;
`ifdef SRAM_BUS_RR_EN
            ptr        <= '0;
`endif
        end else begin
            if (state == ST_IDLE && req_any) begin
                cnt        <= '0;
                we_q       <= m_we[grant_idx];
                waddr_q    <= addr_mux[ADDR_W+1:2];
                sel_q      <= m_sel[grant_idx*SEL_W +: SEL_W];
                bank_q     <= bank_mux;
                grant_oh_q <= grant_oh;
                ram_dq_o   <= m_wdata[grant_idx*DATA_W +: DATA_W];
`ifdef SRAM_BUS_RR_EN
                ptr        <= (grant_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_idx + 1'b1;
`endif
            end
            if (state == ST_ACCESS) begin
                cnt <= cnt + 1'b1;
                if (access_last && !we_q)
                    m_rdata <= ram_dq_i[bank_q*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ram_ce_n  = '1;
        ram_oe_n  = '1;
        ram_we_n  = '1;
        ram_be_n  = '1;
        ram_addr  = '0;
        ram_dq_oe = 1'b0;
        m_ack     = '0;
        case (state)
            ST_IDLE: begin
                if (req_any) state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                ram_ce_n[bank_q]                  = 1'b0;
                ram_be_n[bank_q*SEL_W +: SEL_W]   = ~sel_q;
                ram_addr[bank_q*ADDR_W +: ADDR_W] = waddr_q;
                if (we_q) begin
                    ram_we_n[bank_q] = 1'b0;
                    ram_dq_oe        = 1'b1;
                end else begin
                    ram_oe_n[bank_q] = 1'b0;
                end
                if (access_last) state_nxt = we_q ? ST_HOLD : ST_DONE;
            end
            // Write data stays driven one cycle past the we_n rising edge
            ST_HOLD: begin
                ram_ce_n[bank_q]                  = 1'b0;
                ram_be_n[bank_q*SEL_W +: SEL_W]   = ~sel_q;
                ram_addr[bank_q*ADDR_W +: ADDR_W] = waddr_q;
                ram_dq_oe                         = 1'b1;
                state_nxt                         = ST_DONE;
            end
            ST_DONE: begin
                m_ack     = grant_oh_q;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
